// File: rtl/btn_encoder_if.sv
// rtl/btn_encoder_if.sv - raw button pins in, debounced button vector and flags out
interface btn_encoder_if;
  logic [3:0] raw;
  logic [3:0] btn;
  logic       invalid;
  logic       strobe;
  logic [1:0] code;

  modport master (output raw, input btn, invalid, strobe, code);
  modport slave  (input raw, output btn, invalid, strobe, code);
endinterface

// File: rtl/btn_encoder.sv
// rtl/btn_encoder.sv - debounced 4-button encoder with invalid flag, press strobe and binary code
// Optional BTN_AUTO_REPEAT_EN: repeat strobe every REPEAT_CYC cycles while a single button is held.
module btn_encoder #(
  parameter int DEB_CYC    = 4,
  parameter int REPEAT_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  btn_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);

  if (DEB_CYC < 2 || DEB_CYC > 255 || REPEAT_CYC < 2) begin : g_param_check
    $error("btn_encoder: DEB_CYC must be 2..255 and REPEAT_CYC at least 2");
  end

  state_t     state;
  state_t     state_nxt;
  logic [3:0] sync1;
  logic [3:0] s;
  logic [3:0] cap;
  logic [3:0] cap_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [3:0] btn_q;
  logic [3:0] btn_nxt;
  logic       invalid_q;
  logic       strobe_q;
  logic       strobe_nxt;
  logic [1:0] code_q;

  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else if (v[3]) return 2'd3;
    else           return 2'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'd0;
      s     <= 4'd0;
    end else begin
      sync1 <= bus.raw;
      s     <= sync1;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int REP_W = ($clog2(REPEAT_CYC) < 1) ? 1 : $clog2(REPEAT_CYC);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_fire;

  // Counter only runs while staying in HELD, so entry, exit and glitch returns all restart it.
  always_ff @(posedge clk) begin
    if (rst || state != HELD || state_nxt != HELD || invalid_q || rep_cnt == REP_LAST)
      rep_cnt <= '0;
    else
      rep_cnt <= rep_cnt + 1'b1;
  end

  assign rep_fire = (state == HELD) && (state_nxt == HELD) && !invalid_q && (rep_cnt == REP_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap       <= 4'd0;
      cnt       <= 8'd0;
      btn_q     <= 4'd0;
      invalid_q <= 1'b0;
      strobe_q  <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state     <= state_nxt;
      cap       <= cap_nxt;
      cnt       <= cnt_nxt;
      btn_q     <= btn_nxt;
      invalid_q <= multi_hot(btn_nxt);
      strobe_q  <= strobe_nxt;
      code_q    <= low_index(btn_nxt);
    end
  end

  always_comb begin
    state_nxt = state;
    cap_nxt   = cap;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (s != 4'd0) begin
          state_nxt = DEBOUNCE;
          cap_nxt   = s;
          cnt_nxt   = 8'd0;
        end
      end
      DEBOUNCE: begin
        if (s == 4'd0) begin
          state_nxt = IDLE;
        end else if (s != cap) begin
          cap_nxt = s;
          cnt_nxt = 8'd0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      HELD: begin
        if (s != btn_q) begin
          state_nxt = RELEASE;
          cnt_nxt   = 8'd0;
        end
      end
      RELEASE: begin
        // Any non-matching sample counts toward release, so a set change always drops to btn=0 first.
        if (s == btn_q) begin
          state_nxt = HELD;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    btn_nxt    = btn_q;
    strobe_nxt = 1'b0;
    if (state == DEBOUNCE && state_nxt == HELD) begin
      btn_nxt    = cap;
      strobe_nxt = 1'b1;
    end else if (state == RELEASE && state_nxt == IDLE) begin
      btn_nxt = 4'd0;
    end
`ifdef BTN_AUTO_REPEAT_EN
    else if (rep_fire) begin
      strobe_nxt = 1'b1;
    end
`endif
  end

  assign bus.btn     = btn_q;
  assign bus.invalid = invalid_q;
  assign bus.strobe  = strobe_q;
  assign bus.code    = code_q;

endmodule

// File: tb/tb_btn_encoder.sv
// tb/tb_btn_encoder.sv - scoreboard bench for btn_encoder with DEB_CYC=4, REPEAT_CYC=16
module tb_btn_encoder;

  typedef struct {
    int         at;
    logic [3:0] b;
    logic       inv;
    logic [1:0] cd;
    logic       st;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c;
  ev_t  q[$];
  ev_t  e;
  logic [3:0] prev_btn = 4'd0;

  btn_encoder_if bus();

  btn_encoder #(.DEB_CYC(4), .REPEAT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic expect_ev(input int at, input logic [3:0] b, input logic inv,
                           input logic [1:0] cd, input logic st);
    ev_t x;
    x.at = at; x.b = b; x.inv = inv; x.cd = cd; x.st = st;
    q.push_back(x);
  endtask

  // Events are strobe pulses or any change of btn, observed at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_btn = 4'd0;
    end else begin
      if (bus.strobe || bus.btn != prev_btn) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d btn=%b inv=%b code=%0d strobe=%b",
                   cyc, bus.btn, bus.invalid, bus.code, bus.strobe);
        end else begin
          e = q.pop_front();
          if (cyc != e.at || bus.btn !== e.b || bus.invalid !== e.inv ||
              bus.code !== e.cd || bus.strobe !== e.st) begin
            errors++;
            $display("FAIL event got cyc=%0d btn=%b inv=%b code=%0d strobe=%b expected cyc=%0d btn=%b inv=%b code=%0d strobe=%b",
                     cyc, bus.btn, bus.invalid, bus.code, bus.strobe,
                     e.at, e.b, e.inv, e.cd, e.st);
          end
        end
      end
      prev_btn = bus.btn;
    end
  end

  task automatic press_release(input logic [3:0] r, input logic inv, input logic [1:0] cd);
    c = cyc; bus.raw = r; expect_ev(c + 7, r, inv, cd, 1'b1);
    step(20);
    c = cyc; bus.raw = 4'd0; expect_ev(c + 7, 4'd0, 1'b0, 2'd0, 1'b0);
    step(20);
  endtask

  initial begin
    bus.raw = 4'b1111;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.btn !== 4'd0 || bus.invalid !== 1'b0 || bus.strobe !== 1'b0 || bus.code !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle=%0d btn=%b inv=%b strobe=%b code=%0d required all 0",
                 i, bus.btn, bus.invalid, bus.strobe, bus.code);
      end
    end
    rst = 1'b0;
    bus.raw = 4'd0;
    step(10);

    press_release(4'b0100, 1'b0, 2'd2);

    for (int i = 0; i < 10; i++) begin
      bus.raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      step(1);
    end
    press_release(4'b0100, 1'b0, 2'd2);

    c = cyc; bus.raw = 4'b0001;
    step(2);
    bus.raw = 4'b0011; expect_ev(c + 9, 4'b0011, 1'b1, 2'd0, 1'b1);
    step(20);
    c = cyc; bus.raw = 4'd0; expect_ev(c + 7, 4'd0, 1'b0, 2'd0, 1'b0);
    step(20);

    press_release(4'b1010, 1'b1, 2'd1);
    press_release(4'b1000, 1'b0, 2'd3);

    c = cyc; bus.raw = 4'b0100; expect_ev(c + 7, 4'b0100, 1'b0, 2'd2, 1'b1);
    step(20);
    bus.raw = 4'd0;
    step(2);
    bus.raw = 4'b0100;
    step(20);
    checks++;
    if (bus.btn !== 4'b0100) begin
      errors++;
      $display("FAIL glitch_hold btn=%b required 0100", bus.btn);
    end
    c = cyc; bus.raw = 4'd0; expect_ev(c + 7, 4'd0, 1'b0, 2'd0, 1'b0);
    step(20);

`ifdef BTN_AUTO_REPEAT_EN
    c = cyc; bus.raw = 4'b1000;
    expect_ev(c + 7,  4'b1000, 1'b0, 2'd3, 1'b1);
    expect_ev(c + 23, 4'b1000, 1'b0, 2'd3, 1'b1);
    expect_ev(c + 39, 4'b1000, 1'b0, 2'd3, 1'b1);
    expect_ev(c + 55, 4'b1000, 1'b0, 2'd3, 1'b1);
    wait_until(c + 67);
    c = cyc; bus.raw = 4'd0; expect_ev(c + 7, 4'd0, 1'b0, 2'd0, 1'b0);
    step(20);
    c = cyc; bus.raw = 4'b1001; expect_ev(c + 7, 4'b1001, 1'b1, 2'd0, 1'b1);
    wait_until(c + 67);
    c = cyc; bus.raw = 4'd0; expect_ev(c + 7, 4'd0, 1'b0, 2'd0, 1'b0);
    step(20);
`endif

    step(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events pending=%0d required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btn_encoder.md
Name: btn_encoder

Overview:
- Front-end for the one-hot button decoder. Converts four raw asynchronous push-buttons into a debounced, registered btn[3:0] vector plus an invalid flag.
- invalid is asserted when more than one button is held, so the downstream decoder suppresses every output.
- Also emits a one-cycle strobe per accepted press and a 2-bit binary code of the pressed button.
- Sits between the board pins and the decoder's btn/invalid inputs.

Parameters:
- DEB_CYC, 4: consecutive stable cycles required to accept a press or a release. Legal range 2..255.
- REPEAT_CYC, 16: auto-repeat period in cycles. Used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- raw  input  4  raw button levels, asynchronous; 1 = pressed.
- btn  output 4  debounced held-button vector; feeds decoder btn.
- invalid  output 1  1 when popcount(btn) > 1; feeds decoder invalid.
- strobe  output 1  one-cycle pulse when a new press is accepted.
- code  output 2  index of the lowest set bit of btn; 0 when btn == 0.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - rst held at a rising edge gives btn=0, invalid=0, strobe=0, code=0, sync flops=0, state=IDLE, counter=0.
  - Reset mid-press aborts immediately. No strobe is issued for the aborted press.
- Synchronizer: two-flop synchronizer on raw produces s[3:0]. All FSM decisions use s only.
- Internal registers: cap[3:0] (captured sample) and cnt (8 bits).
- Outputs: all outputs are registered. invalid and code are recomputed from the value being loaded into btn, on the same edge.
- IDLE state:
  - btn=0.
  - If s != 0: go to DEBOUNCE, cap <= s, cnt <= 0.
- DEBOUNCE state:
  - If s == 0: return to IDLE. Outputs unchanged, no strobe.
  - Else if s != cap: cap <= s, cnt <= 0. Restarts the count, so a second button joining mid-debounce restarts it.
  - Else if cnt == DEB_CYC-1: go to HELD, btn <= cap, strobe <= 1 for exactly one cycle.
  - Else: cnt <= cnt+1.
- HELD state:
  - btn stays constant.
  - If s != btn: go to RELEASE, cnt <= 0.
- RELEASE state:
  - If s == btn: glitch; return to HELD with no strobe.
  - Else if cnt == DEB_CYC-1: go to IDLE, btn <= 0 (invalid=0, code=0).
  - Else: cnt <= cnt+1.
  - A changed but nonzero s ends in IDLE first. The new combination is then debounced from IDLE. A set change therefore always passes through btn=0.
- Latency:
  - Edge 0 is the first rising edge that samples a new stable raw.
  - Press: btn and strobe update on edge DEB_CYC+2.
  - Release: btn clears on edge DEB_CYC+2.
- Strobe rules:
  - strobe is never asserted in two consecutive cycles.
  - strobe is asserted for invalid presses too. The decoder masks them.
- Multi-button press: popcount >= 2 gives invalid=1. code is the lowest set index, e.g. btn=1010 gives code=1.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - A repeat counter is cleared on entry to HELD.
  - While in HELD with invalid == 0, strobe pulses again every REPEAT_CYC cycles. The first repeat comes REPEAT_CYC cycles after the initial strobe.
  - Leaving HELD, including entering RELEASE, clears the repeat counter. A glitch back to HELD restarts the repeat period.
  - No repeat is issued while invalid == 1.
- Undefined: exactly one strobe per accepted press. No repeat counter logic is present.

Test Plan (DEB_CYC=4, REPEAT_CYC=16):
- Reset: hold rst with raw=1111 for 3 cycles -> all outputs 0 throughout; state stays IDLE after rst drops with raw=0.
- Clean press: raw=0100 from edge 0 -> btn=0100, code=2, invalid=0, strobe=1 exactly on edge 6; strobe 0 on edge 7.
- Bounce: raw toggles 0100/0000 every cycle for 10 cycles, then holds 0100 -> no strobe during bouncing; strobe 6 edges after the last toggle.
- Multi-press: raw=0001, then 0011 two cycles later -> debounce restarts; btn=0011, invalid=1, code=0, one strobe.
- Release: from btn=0100, raw=0 at edge 0 -> btn=0 on edge 6; a 2-cycle release glitch instead keeps btn=0100 with no strobe.
- With BTN_AUTO_REPEAT_EN: hold raw=1000 for 60 cycles after the initial strobe -> strobes at +16, +32 and +48 cycles; hold raw=1001 instead -> no repeats.
